sw_debounce: RTL and testbench



---
 rtl/sw_pkg.sv | 25 ++
 rtl/sw_debounce_bit.sv | 74 +++++++
 rtl/sw_debounce.sv | 52 +++++
 tb/tb_sw_debounce.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and types for the slide-switch debouncer.
// Imported by the per-bit debouncer and the top level.
package sw_pkg;

  localparam int SW_N               = 5;
  localparam int DB_CNT_10MS_100MHZ = 1000000;
  localparam int DB_CNT_SIM         = 4;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Direction of an accepted transition; only meaningful once the window has expired.
  function automatic edge_e edge_dir(input logic s, input logic db, input logic window_done);
    edge_e dir;
    dir = EDGE_NONE;
    if (window_done && (s != db)) begin
      dir = s ? EDGE_RISE : EDGE_FALL;
    end
    return dir;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, saturating stability counter,
// debounced output flop and registered rise/fall strobes.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int CNT_MAX = DB_CNT_10MS_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_nxt_o,
  output logic fall_nxt_o
);

  localparam int                CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  edge_e            edge_d;

  always_comb begin
    sync1_d = sw_i;
    s_d     = sync1_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    edge_d  = edge_dir(s_q, db_q, cnt_q == CNT_LAST);

    // Any agreement between s and db restarts the window: no partial credit.
    if (s_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    rise_d = (edge_d == EDGE_RISE);
    fall_d = (edge_d == EDGE_FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_o       = db_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign rise_nxt_o = rise_d;
  assign fall_nxt_o = fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch bus: N independent bit debouncers plus a
// registered any-change strobe aligned with the per-bit strobes.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int N       = SW_N,
  parameter int CNT_MAX = DB_CNT_10MS_100MHZ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         any_chg
);

  logic [N-1:0] rise_nxt;
  logic [N-1:0] fall_nxt;
  logic         any_chg_q, any_chg_d;

  for (genvar i = 0; i < N; i++) begin : g_bit
    debounce_bit #(
      .CNT_MAX (CNT_MAX)
    ) u_bit (
      .clk        (clk),
      .rst        (rst),
      .sw_i       (sw[i]),
      .db_o       (sw_db[i]),
      .rise_o     (sw_rise[i]),
      .fall_o     (sw_fall[i]),
      .rise_nxt_o (rise_nxt[i]),
      .fall_nxt_o (fall_nxt[i])
    );
  end

  // Built from next-state strobes so it lands in the same cycle as sw_rise/sw_fall.
  always_comb begin
    any_chg_d = |(rise_nxt | fall_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_chg_q <= 1'b0;
    end else begin
      any_chg_q <= any_chg_d;
    end
  end

  assign any_chg = any_chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with CNT_MAX=4, N=5.
module tb_sw_debounce;
  import sw_pkg::*;

  typedef struct packed {
    logic [4:0] db;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       any;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sw;
  logic [4:0] sw_db, sw_rise, sw_fall;
  logic       any_chg;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] db_model = 5'b0;

  sw_debounce #(
    .N       (SW_N),
    .CNT_MAX (DB_CNT_SIM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .any_chg (any_chg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  function automatic exp_t obs();
    return {sw_db, sw_rise, sw_fall, any_chg};
  endfunction

  // Expected outputs j edges after a new pin value o->n is first captured:
  // the debounced vector updates on edge j=5 (CNT_MAX+1) with one-cycle strobes.
  function automatic exp_t exp_at(input logic [4:0] o, input logic [4:0] n, input int j);
    exp_t r;
    r.db   = (j >= 5) ? n : o;
    r.rise = (j == 5) ? (n & ~o) : 5'b0;
    r.fall = (j == 5) ? (o & ~n) : 5'b0;
    r.any  = (j == 5) && (o != n);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sw  = 5'b10101;
    repeat (3) exp_q.push_back('0);
    repeat (3) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_hold: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                 sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
      end
    end
    rst = 1'b0;
    for (int j = 0; j < 8; j++) exp_q.push_back(exp_at(5'b0, 5'b10101, j));
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                 j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
      end
    end
    db_model = 5'b10101;
  endtask

  task automatic test_clean_change();
    logic [4:0] seq [2];
    seq[0] = 5'b00000;
    seq[1] = 5'b00001;
    for (int s = 0; s < 2; s++) begin
      sw = seq[s];
      for (int j = 0; j < 8; j++) begin
        exp_q.push_back(exp_at(db_model, seq[s], j));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL clean_change step %0d edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                   s, j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
        end
      end
      db_model = seq[s];
    end
  endtask

  task automatic test_glitch();
    logic pat;
    sw = 5'b00000;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(exp_at(db_model, 5'b00000, j));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL glitch_settle edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                 j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
      end
    end
    // Two 3-cycle highs separated by 2-cycle lows, then a stable high from k=10.
    for (int k = 0; k < 18; k++) begin
      pat = (k < 10) ? ((k % 5) < 3) : 1'b1;
      sw  = {3'b000, pat, 1'b0};
      exp_q.push_back(exp_at(5'b00000, 5'b00010, k - 10));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                 k, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
      end
    end
    db_model = 5'b00010;
  endtask

  task automatic test_simultaneous();
    logic [4:0] seq [2];
    seq[0] = 5'b00000;
    seq[1] = 5'b11111;
    for (int s = 0; s < 2; s++) begin
      sw = seq[s];
      for (int j = 0; j < 8; j++) begin
        exp_q.push_back(exp_at(db_model, seq[s], j));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL simultaneous step %0d edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                   s, j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
        end
      end
      db_model = seq[s];
    end
  endtask

  task automatic test_fall_midreset();
    sw = 5'b01111;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(exp_at(db_model, 5'b01111, j));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL fall edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                 j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
      end
    end
    db_model = 5'b01111;
    // Drop sw[3]; reset lands on the 3rd edge and lasts two edges.
    sw = 5'b00111;
    for (int j = 0; j < 4; j++) begin
      rst = (j >= 2);
      exp_q.push_back((j >= 2) ? exp_t'('0) : exp_at(db_model, 5'b00111, j));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL midcount_reset edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                 j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
      end
    end
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(exp_at(5'b00000, 5'b00111, j));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL after_reset edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                 j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
      end
    end
    db_model = 5'b00111;
  endtask

  task automatic test_parity_consumer();
    logic [4:0] v;
    logic [4:0] gmask;
    for (int t = 0; t < 20; t++) begin
      v     = 5'($urandom_range(0, 31));
      gmask = 5'(1 << $urandom_range(0, 4));
      for (int j = 0; j < 10; j++) begin
        // Two-cycle bounce on one bit after the value has settled.
        sw = (j == 6 || j == 7) ? (v ^ gmask) : v;
        exp_q.push_back(exp_at(db_model, v, j));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_checks++;
        if ((^sw_db) !== (^e.db)) begin
          n_fail++;
          $display("FAIL parity trial %0d edge %0d: got parity=%b, expected parity=%b",
                   t, j, ^sw_db, ^e.db);
        end
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL consumer trial %0d edge %0d: got db=%b rise=%b fall=%b any=%b, expected db=%b rise=%b fall=%b any=%b",
                   t, j, sw_db, sw_rise, sw_fall, any_chg, e.db, e.rise, e.fall, e.any);
        end
      end
      db_model = v;
    end
  endtask

  initial begin
    rst = 1'b1;
    sw  = 5'b0;
    test_reset();
    test_clean_change();
    test_glitch();
    test_simultaneous();
    test_fall_midreset();
    test_parity_consumer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
